// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// burst FSM state type and the burst shift-direction helper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_e;

  // A burst is just a plain serial shift in the configured direction, so it
  // reuses the normal shift operations (and their fill-bit selection).
  function automatic logic [2:0] burst_shift_mode(input bit lsb_first);
    return lsb_first ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/usr_next_value.sv
// Combinational next-value mux for the shift register: selects the new
// register contents from the operation code, current value, parallel input
// and the serial fill bits.
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] i_par_i,
  input  logic             msb_in_i,
  input  logic             lsb_in_i,
  output logic [WIDTH-1:0] a_next_o
);

  // One result per operation code; hold is the fallback.
  always_comb begin
    a_next_o = a_i;
    case (mode_i)
      MODE_HOLD: a_next_o = a_i;
      MODE_SHR:  a_next_o = {msb_in_i, a_i[WIDTH-1:1]};
      MODE_SHL:  a_next_o = {a_i[WIDTH-2:0], lsb_in_i};
      MODE_LOAD: a_next_o = i_par_i;
      MODE_ROR:  a_next_o = {a_i[0], a_i[WIDTH-1:1]};
      MODE_ROL:  a_next_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
      MODE_ASR:  a_next_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
      MODE_CLR:  a_next_o = '0;
      default:   a_next_o = a_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register with a self-timed burst mode that loads a
// word and serialises it over WIDTH cycles, reporting busy/done.
// The burst FSM steers the operation code fed to the shared next-value mux:
// load on the accepting edge, then a fixed-direction shift every busy cycle.
module universal_shift_register_n
  import usr_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter bit BURST_LSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  output logic [WIDTH-1:0] A_par,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             done_q, done_d;
  logic [2:0]       op_mode;

  usr_next_value #(
    .WIDTH(WIDTH)
  ) u_next_value (
    .mode_i   (op_mode),
    .a_i      (a_q),
    .i_par_i  (I_par),
    .msb_in_i (MSB_in),
    .lsb_in_i (LSB_in),
    .a_next_o (a_d)
  );

  // FSM state register; reset aborts any burst in flight.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only counts in IDLE, burst ends on the last shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_BURST;
      ST_BURST: if (cnt_q == CNT_ONE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: operation select, counter update and done request.
  // During a burst, mode and start are ignored entirely.
  always_comb begin
    op_mode = mode;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_mode = MODE_LOAD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BURST: begin
        op_mode = burst_shift_mode(BURST_LSB_FIRST);
        cnt_d   = cnt_q - CNT_ONE;
        done_d  = (cnt_q == CNT_ONE);
      end
      default: begin
        op_mode = mode;
      end
    endcase
  end

  // Datapath registers: register contents, shift counter and done pulse.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      a_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign A_par   = a_q;
  assign MSB_out = a_q[WIDTH-1];
  assign LSB_out = a_q[0];
  assign busy    = (state_q == ST_BURST);
  assign done    = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Self-checking bench for universal_shift_register_n: an 8-bit LSB-first
// instance and a 4-bit MSB-first instance share one clock. Expected values
// are queued when stimulus is applied and compared when the DUT responds.
module tb_universal_shift_register_n;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 8-bit, LSB-first instance
  logic       rst8_b, msb8, lsb8, start8;
  logic [2:0] mode8;
  logic [7:0] ipar8, a8;
  logic       msbo8, lsbo8, busy8, done8;

  // 4-bit, MSB-first instance
  logic       rst4_b, msb4, lsb4, start4;
  logic [2:0] mode4;
  logic [3:0] ipar4, a4;
  logic       msbo4, lsbo4, busy4, done4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  universal_shift_register_n #(.WIDTH(8), .BURST_LSB_FIRST(1'b1)) u_dut8 (
    .CLK(CLK), .Clear_b(rst8_b), .mode(mode8), .I_par(ipar8),
    .MSB_in(msb8), .LSB_in(lsb8), .start(start8),
    .A_par(a8), .MSB_out(msbo8), .LSB_out(lsbo8), .busy(busy8), .done(done8)
  );

  universal_shift_register_n #(.WIDTH(4), .BURST_LSB_FIRST(1'b0)) u_dut4 (
    .CLK(CLK), .Clear_b(rst4_b), .mode(mode4), .I_par(ipar4),
    .MSB_in(msb4), .LSB_in(lsb4), .start(start4),
    .A_par(a4), .MSB_out(msbo4), .LSB_out(lsbo4), .busy(busy4), .done(done4)
  );

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    exp_q.push_back(32'h0);
    @(negedge CLK);
    e = exp_q.pop_front();
    n_checks++;
    if (a8 !== e[7:0] || busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL reset_state: A=%h busy=%b done=%b expected A=%h busy=0 done=0", a8, busy8, done8, e[7:0]);
    else n_pass++;

    mode8 = 3'b011; ipar8 = 8'hA5;
    exp_q.push_back(32'hA5);
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (a8 !== e[7:0]) $display("FAIL reset_preload: A=%h expected %h", a8, e[7:0]);
    else n_pass++;

    mode8 = 3'b000;
    exp_q.push_back(32'h0);
    #1 rst8_b = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (a8 !== e[7:0] || busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL reset_async: A=%h busy=%b done=%b expected A=%h busy=0 done=0", a8, busy8, done8, e[7:0]);
    else n_pass++;
    #1 rst8_b = 1'b1;

    exp_q.push_back(32'h0);
    step();
    e = exp_q.pop_front();
    n_checks++;
    if (a8 !== e[7:0]) $display("FAIL reset_hold_after: A=%h expected %h", a8, e[7:0]);
    else n_pass++;
  endtask

  task automatic test_modes();
    logic [31:0] e;
    logic [2:0]  t_mode[7] = '{3'b011, 3'b001, 3'b101, 3'b110, 3'b010, 3'b100, 3'b111};
    logic        t_msb [7] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    logic        t_lsb [7] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1};
    logic [7:0]  t_exp [7] = '{8'hA5,  8'hD2,  8'hA5,  8'hD2,  8'hA4,  8'h52,  8'h00};
    ipar8 = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      mode8 = t_mode[i]; msb8 = t_msb[i]; lsb8 = t_lsb[i];
      exp_q.push_back({24'd0, t_exp[i]});
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (a8 !== e[7:0]) $display("FAIL mode_%b_step%0d: A=%h expected %h", t_mode[i], i, a8, e[7:0]);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (msbo8 !== 1'b1 || lsbo8 !== 1'b1)
          $display("FAIL serial_outs_A5: MSB_out=%b LSB_out=%b expected 1 1", msbo8, lsbo8);
        else n_pass++;
      end
    end
    mode8 = 3'b011; ipar8 = 8'h3C;
    step();
    mode8 = 3'b000; ipar8 = 8'hFF;
    exp_q.push_back(32'h3C);
    step(); step();
    e = exp_q.pop_front();
    n_checks++;
    if (a8 !== e[7:0]) $display("FAIL mode_hold: A=%h expected %h", a8, e[7:0]);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [31:0] e;
    mode8 = 3'b000; msb8 = 1'b1; lsb8 = 1'b0; ipar8 = 8'hA5; start8 = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back({31'd0, ipar8[k]});
    step();
    start8 = 1'b0; ipar8 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || lsbo8 !== e[0])
        $display("FAIL burst_bit%0d: busy=%b done=%b LSB_out=%b expected busy=1 done=0 LSB_out=%b", k, busy8, done8, lsbo8, e[0]);
      else n_pass++;
      step();
    end
    exp_q.push_back(32'hFF);
    e = exp_q.pop_front();
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || a8 !== e[7:0])
      $display("FAIL burst_done: done=%b busy=%b A=%h expected done=1 busy=0 A=%h", done8, busy8, a8, e[7:0]);
    else n_pass++;
    step();
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL burst_done_clear: done=%b busy=%b expected 0 0", done8, busy8);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] e;
    logic        saw_done;
    msb8 = 1'b0; ipar8 = 8'h3C; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    exp_q.push_back({31'd0, 1'b1});
    e = exp_q.pop_front();
    n_checks++;
    if (busy8 !== 1'b1 || lsbo8 !== e[0])
      $display("FAIL midburst_cycle3: busy=%b LSB_out=%b expected busy=1 LSB_out=%b", busy8, lsbo8, e[0]);
    else n_pass++;
    #1 rst8_b = 1'b0;
    #1;
    n_checks++;
    if (a8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL midburst_reset: A=%h busy=%b done=%b expected A=00 busy=0 done=0", a8, busy8, done8);
    else n_pass++;
    #1 rst8_b = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL midburst_no_done: activity seen=%b expected 0", saw_done);
    else n_pass++;

    ipar8 = 8'h96; start8 = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back({31'd0, ipar8[k]});
    step();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy8 !== 1'b1 || lsbo8 !== e[0])
        $display("FAIL restart_bit%0d: busy=%b LSB_out=%b expected busy=1 LSB_out=%b", k, busy8, lsbo8, e[0]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || a8 !== 8'h00)
      $display("FAIL restart_done: done=%b busy=%b A=%h expected 1 0 00", done8, busy8, a8);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [7:0]  second = 8'h5A;
    msb8 = 1'b0; mode8 = 3'b000; ipar8 = 8'hC9; start8 = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back({31'd0, ipar8[k]});
    step();
    start8 = 1'b0; ipar8 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy8 !== 1'b1 || lsbo8 !== e[0])
        $display("FAIL ignore_bit%0d: busy=%b LSB_out=%b expected busy=1 LSB_out=%b", k, busy8, lsbo8, e[0]);
      else n_pass++;
      if (k == 2 || k == 4) begin
        start8 = 1'b1; mode8 = 3'b111; ipar8 = 8'hFF;
      end else if (k == 7) begin
        start8 = 1'b1; mode8 = 3'b000; ipar8 = second;
      end else begin
        start8 = 1'b0; mode8 = 3'b000; ipar8 = 8'h00;
      end
      step();
    end
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL b2b_done: done=%b busy=%b expected 1 0", done8, busy8);
    else n_pass++;
    for (int k = 0; k < 8; k++) exp_q.push_back({31'd0, second[k]});
    step();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || lsbo8 !== e[0])
        $display("FAIL b2b_bit%0d: busy=%b done=%b LSB_out=%b expected busy=1 done=0 LSB_out=%b", k, busy8, done8, lsbo8, e[0]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL b2b_second_done: done=%b busy=%b expected 1 0", done8, busy8);
    else n_pass++;
    step();
  endtask

  task automatic test_width4_msb_first();
    logic [31:0] e;
    logic [2:0]  t_mode[5] = '{3'b011, 3'b000, 3'b001, 3'b010, 3'b011};
    logic [3:0]  t_exp [5] = '{4'b1010, 4'b1010, 4'b1101, 4'b1010, 4'b1010};
    ipar4 = 4'b1010; msb4 = 1'b1; lsb4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode4 = t_mode[i];
      if (i == 4) begin
        mode4 = 3'b111;
        step();
        mode4 = 3'b011;
      end
      exp_q.push_back({28'd0, t_exp[i]});
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (a4 !== e[3:0]) $display("FAIL w4_mode_%b_step%0d: A=%b expected %b", t_mode[i], i, a4, e[3:0]);
      else n_pass++;
    end
    n_checks++;
    if (msbo4 !== 1'b1 || lsbo4 !== 1'b0)
      $display("FAIL w4_serial_outs: MSB_out=%b LSB_out=%b expected 1 0", msbo4, lsbo4);
    else n_pass++;

    mode4 = 3'b000; start4 = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({31'd0, ipar4[3-k]});
    step();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (busy4 !== 1'b1 || msbo4 !== e[0])
        $display("FAIL w4_burst_bit%0d: busy=%b MSB_out=%b expected busy=1 MSB_out=%b", k, busy4, msbo4, e[0]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || a4 !== 4'b0000)
      $display("FAIL w4_burst_done: done=%b busy=%b A=%b expected 1 0 0000", done4, busy4, a4);
    else n_pass++;
    step();
    n_checks++;
    if (done4 !== 1'b0) $display("FAIL w4_done_clear: done=%b expected 0", done4);
    else n_pass++;
  endtask

  initial begin
    rst8_b = 1'b0; mode8 = 3'b000; ipar8 = 8'h00; msb8 = 1'b0; lsb8 = 1'b0; start8 = 1'b0;
    rst4_b = 1'b0; mode4 = 3'b000; ipar4 = 4'h0;  msb4 = 1'b0; lsb4 = 1'b0; start4 = 1'b0;
    #12;
    rst8_b = 1'b1;
    rst4_b = 1'b1;
    test_reset();
    test_modes();
    test_burst();
    test_reset_mid_burst();
    test_back_to_back();
    test_width4_msb_first();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
